enc_poll_ctrl: RTL
==================

Name: enc_poll_ctrl

Overview:
- Periodic snapshot and readout sequencer for the encoder register block.
- Pulses global_snapshot on a programmable timer tick or on an encoder-change event, then reads the 32-bit snapshots of the enabled channels over the encoder block's read port.
- Presents each result as a (channel, position) stream.
- Shares the encoder block's read port with host reads: the host has priority at read-slot boundaries.

Parameters:
- ENC_BAR, 'h0, base address of the encoder register block; snapshot low word of channel c is at ENC_BAR+'h40+8*c, high word at +2.
- NCH, 8, number of channels scanned (1..8).

Ports:
- clk  in  1  system clock
- aclr  in  1  asynchronous active-high reset
- sclr  in  1  synchronous clear, same effect as aclr
- cfg_ena  in  1  sequencer enable
- cfg_period  in  32  tick period in clk cycles; 0 = timer off
- cfg_mask  in  8  channel scan mask (bit c set = read channel c)
- cfg_trig_chg  in  1  also start a scan on any enc_changed bit
- enc_changed  in  2  change pulses from the encoder block
- global_snapshot  out  1  one-cycle snapshot strobe to the encoder block
- enc_rdaddr  out  16  read address to the encoder block
- enc_rddata  in  16  registered read data; valid 1 cycle after its address
- host_rd  in  1  host read request (held until host_ack)
- host_addr  in  16  host read address
- host_ack  out  1  1-cycle grant; host address is driven to the encoder block this cycle
- host_rdvalid  out  1  host_rddata valid (1 cycle after host_ack)
- host_rddata  out  16  host read data
- out_valid  out  1  result valid
- out_ready  in  1  result accepted when valid && ready
- out_ch  out  3  channel of the result
- out_pos  out  32  snapshot position (signed, passed through unmodified)
- busy  out  1  scan in progress (state != IDLE)
- overrun  out  1  sticky: a trigger arrived while busy; cleared by sclr/aclr only

Behaviour:
- Reset (aclr or sclr): state = IDLE; timer = 0; global_snapshot = 0; out_valid = 0; out_ch = 0; out_pos = 0; host_ack = 0; host_rdvalid = 0; host_rddata = 0; overrun = 0; enc_rdaddr = 'hFFFF.
- enc_rdaddr holds 'hFFFF whenever no slot is granted, so the encoder block returns 0.
- Timer: runs only when cfg_ena && cfg_period != 0.
  - Counts 0..cfg_period-1; tick is asserted on the cycle the count equals cfg_period-1, then the count wraps to 0.
  - Changing cfg_period while the count is at or above the new value forces a wrap (tick) next cycle.
  - cfg_ena = 0 holds the count at 0.
- Trigger = tick OR (cfg_trig_chg && |enc_changed && cfg_ena).
  - Trigger in IDLE starts a scan.
  - Trigger in any other state is dropped and sets overrun.
  - A tick and a change in the same cycle count as a single trigger.
- States:
  - IDLE: trigger -> SNAP.
  - SNAP: global_snapshot = 1 for exactly this cycle; capture cfg_mask into scan_mask; ch = lowest set bit; -> SETTLE. If scan_mask = 0 -> IDLE (snapshot still issued).
  - SETTLE: 1 cycle for the snapshot registers to update -> RD_LO.
  - RD_LO: if host_rd, grant the host this cycle (host_ack = 1, enc_rdaddr = host_addr) and stay. Otherwise drive the address of ch's low word -> RD_HI.
  - RD_HI: drive the address of ch's high word; capture enc_rddata into pos[15:0] -> CAP.
  - CAP: capture enc_rddata into pos[31:16]; load out_ch/out_pos; set out_valid -> PUSH.
  - PUSH: hold out_valid/out_ch/out_pos stable until out_ready. On the handshake, clear ch from scan_mask; next ch = lowest remaining bit -> RD_LO; if none -> IDLE.
- Host arbitration:
  - In IDLE, SETTLE and PUSH, a pending host_rd is granted immediately.
  - In RD_LO the host is also granted and the sequencer waits; the lo/hi pair of one channel is never split by a host read.
  - At most one host grant per cycle. host_rdvalid and host_rddata follow 1 cycle after host_ack.
  - The host is never granted in SNAP, RD_HI or CAP; host_rd stays pending until granted.
- Clearing cfg_ena mid-scan does not abort the scan; it only stops new triggers.
- Channels with index >= NCH are ignored in the mask.

Test Plan:
- Timer: cfg_period = 10, mask = 'h01, out_ready = 1 -> global_snapshot every 10 cycles; each pulse followed by one result, out_ch = 0, out_pos = channel 0 snapshot (e.g. 'hFFFF_FFFE for -2).
- Mask 'hA5 -> results in channel order 0, 2, 5, 7; each out_pos matches its preloaded value; busy drops after ch7 is accepted.
- Backpressure: out_ready held low 20 cycles mid-scan -> out_valid/out_ch/out_pos stable; no extra enc reads; resumes on ready.
- Host contention: host_rd held continuously during a scan -> granted in RD_LO/PUSH slots; lo/hi pairs never split; host_rddata equals the register at host_addr (e.g. 'h4 -> ena).
- Overrun: cfg_period = 4 with a 3-channel scan -> overrun = 1; extra triggers dropped; scan results still correct.
- aclr asserted in RD_HI -> all outputs return to reset values the same cycle; next trigger starts a clean scan.

Source files
------------

// File: rtl/enc_poll_ctrl.sv
// Snapshot/readout sequencer for the encoder register block. It strobes global_snapshot
// on a timer tick or a change event, reads the enabled channels, and shares the read port with the host.
module enc_poll_ctrl #(
    parameter logic [15:0] ENC_BAR = 16'h0,
    parameter int unsigned NCH     = 8
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        sclr,
    input  logic        cfg_ena,
    input  logic [31:0] cfg_period,
    input  logic [7:0]  cfg_mask,
    input  logic        cfg_trig_chg,
    input  logic [1:0]  enc_changed,
    output logic        global_snapshot,
    output logic [15:0] enc_rdaddr,
    input  logic [15:0] enc_rddata,
    input  logic        host_rd,
    input  logic [15:0] host_addr,
    output logic        host_ack,
    output logic        host_rdvalid,
    output logic [15:0] host_rddata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_ch,
    output logic [31:0] out_pos,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned CW = 3;
    localparam int unsigned MW = 8;
    localparam int unsigned PW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    localparam logic [MW-1:0] CH_MASK   = MW'((64'd1 << NCH) - 64'd1);
    localparam logic [AW-1:0] SNAP_BASE = ENC_BAR + AW'(16'h40);

    typedef enum logic [2:0] {IDLE, SNAP, SETTLE, RD_LO, RD_HI, CAP, PUSH} state_t;

    // Every register of the block; outputs are driven straight from here.
    typedef struct packed {
        state_t          state;
        logic [PW-1:0]   timer;
        logic [MW-1:0]   scan_mask;
        logic [CW-1:0]   ch;
        logic [DW-1:0]   pos_lo;
        logic            snap;
        logic [AW-1:0]   rdaddr;
        logic            hack;
        logic            hvalid;
        logic            ovalid;
        logic [CW-1:0]   och;
        logic [PW-1:0]   opos;
        logic            busy;
        logic            overrun;
    } regs_t;

    localparam regs_t RST_VAL = '{
        state: IDLE, timer: '0, scan_mask: '0, ch: '0, pos_lo: '0, snap: 1'b0,
        rdaddr: '1, hack: 1'b0, hvalid: 1'b0, ovalid: 1'b0, och: '0, opos: '0,
        busy: 1'b0, overrun: 1'b0
    };

    function automatic logic [CW-1:0] lowest(input logic [MW-1:0] m);
        lowest = '0;
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (m[i]) lowest = CW'(i);
        end
    endfunction

    function automatic logic [AW-1:0] lo_addr(input logic [CW-1:0] c);
        lo_addr = SNAP_BASE + AW'({c, 3'b000});
    endfunction

    regs_t         r;
    regs_t         n;
    logic          timer_on;
    logic          tick;
    logic          trig;
    logic          host_pend;
    logic [MW-1:0] m;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r <= RST_VAL;
        end else if (sclr) begin
            r <= RST_VAL;
        end else begin
            r <= n;
        end
    end

    always_comb begin
        n         = r;
        m         = '0;
        timer_on  = cfg_ena && (cfg_period != '0);
        tick      = timer_on && (r.timer >= cfg_period - 32'd1);
        n.timer   = (!timer_on || tick) ? '0 : r.timer + 32'd1;
        trig      = tick || (cfg_trig_chg && (|enc_changed) && cfg_ena);
        host_pend = host_rd && !r.hack;

        if (trig && r.state != IDLE) n.overrun = 1'b1;

        case (r.state)
            IDLE:   if (trig) n.state = SNAP;
            SNAP: begin
                m           = cfg_mask & CH_MASK;
                n.scan_mask = m;
                n.ch        = lowest(m);
                n.state     = (m == '0) ? IDLE : SETTLE;
            end
            SETTLE: n.state = RD_LO;
            // A host slot in RD_LO just delays the low-word read by one cycle.
            RD_LO:  if (!r.hack) n.state = RD_HI;
            RD_HI: begin
                n.pos_lo = enc_rddata;
                n.state  = CAP;
            end
            CAP: begin
                n.ovalid = 1'b1;
                n.och    = r.ch;
                n.opos   = {enc_rddata, r.pos_lo};
                n.state  = PUSH;
            end
            PUSH: begin
                m = r.scan_mask & ~(MW'(1) << r.ch);
                if (out_ready) begin
                    n.ovalid    = 1'b0;
                    n.scan_mask = m;
                    n.ch        = lowest(m);
                    n.state     = (m == '0) ? IDLE : RD_LO;
                end
            end
            default: n.state = IDLE;
        endcase

        // Slot owner for the coming cycle follows the state being entered.
        n.busy   = (n.state != IDLE);
        n.snap   = (n.state == SNAP);
        n.hvalid = r.hack;
        n.hack   = 1'b0;
        n.rdaddr = '1;
        case (n.state)
            IDLE, SETTLE, PUSH: begin
                if (host_pend) begin
                    n.hack   = 1'b1;
                    n.rdaddr = host_addr;
                end
            end
            RD_LO: begin
                if (host_pend) begin
                    n.hack   = 1'b1;
                    n.rdaddr = host_addr;
                end else begin
                    n.rdaddr = lo_addr(n.ch);
                end
            end
            RD_HI:   n.rdaddr = lo_addr(n.ch) + AW'(2);
            default: n.rdaddr = '1;
        endcase
    end

    assign global_snapshot = r.snap;
    assign enc_rdaddr      = r.rdaddr;
    assign host_ack        = r.hack;
    assign host_rdvalid    = r.hvalid;
    // Encoder read data is already registered; only gate it onto the host bus.
    assign host_rddata     = r.hvalid ? enc_rddata : '0;
    assign out_valid       = r.ovalid;
    assign out_ch          = r.och;
    assign out_pos         = r.opos;
    assign busy            = r.busy;
    assign overrun         = r.overrun;

endmodule
